// File: rtl/mfp_ahb_ram_slave_ws_pkg.sv
// Shared AHB-Lite encodings and helpers for the wait-state RAM slave.
// Byte-lane mask and legality decode live here so the top stays focused on timing.
package mfp_ahb_ram_slave_ws_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] m;
        case (size)
            HSIZE_BYTE: m = 4'b0001 << a;
            HSIZE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
            default:    m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic size_legal(input logic [2:0] size, input logic [1:0] a);
        logic ok;
        case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = ~a[0];
            HSIZE_WORD: ok = (a == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mfp_ahb_ram_slave_ws_ram.sv
// One byte lane of the slave RAM: synchronous read port, independent write port.
// A read and write to the same address on one edge returns the old contents.
module mfp_dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  i_clk,
    input  logic [ADDR_WIDTH-1:0] i_read_addr,
    input  logic [ADDR_WIDTH-1:0] i_write_addr,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic                  i_write_enable,
    output logic [DATA_WIDTH-1:0] o_read_data
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_write_enable)
            r_mem[i_write_addr] <= i_write_data;
        r_rdata <= r_mem[i_read_addr];
    end

    assign o_read_data = r_rdata;

endmodule

// File: rtl/mfp_ahb_ram_slave_ws.sv
// AHB-Lite RAM slave with configurable wait states, byte-lane writes,
// store forwarding for write->read on one word, and ERROR on misaligned/oversize.
module mfp_ahb_ram_slave_ws
    import mfp_ahb_ram_slave_ws_pkg::*;
#(
    parameter int ADDR_WIDTH  = 6,
    parameter int WAIT_STATES = 0,
    parameter int CHECK_ALIGN = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [2:0]  HBURST,
    input  logic        HMASTLOCK,
    input  logic [3:0]  HPROT,
    input  logic        HSEL,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP,
    input  logic        SI_Endian
);

    state_t                r_state;
    logic                  r_hready;
    logic                  r_hresp;
    logic [2:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_mask;
    logic                  r_write;
    logic                  r_fwd_sel;
    logic                  r_fwd_vld;
    logic [ADDR_WIDTH-1:0] r_fwd_addr;
    logic [3:0]            r_fwd_mask;
    logic [31:0]           r_fwd_data;

    logic                  w_accept;
    logic                  w_legal;
    logic [3:0]            w_mask_in;
    logic [ADDR_WIDTH-1:0] w_haddr_w;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic                  w_last;
    logic                  w_we;
    logic                  w_fwd_use;
    logic [31:0]           w_ram_rdata;
    logic [31:0]           w_merged;
    logic                  w_unused;

    assign w_unused  = ^{HBURST, HMASTLOCK, HPROT, SI_Endian, HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    assign w_accept  = HSEL && HTRANS[1] && r_hready;
    assign w_haddr_w = HADDR[ADDR_WIDTH+1:2];
    assign w_legal   = (CHECK_ALIGN == 0) || size_legal(HSIZE, HADDR[1:0]);
    assign w_mask_in = (CHECK_ALIGN != 0) ? byte_mask(HSIZE, HADDR[1:0]) : 4'b1111;
    assign w_last    = (r_state == ST_DATA) && r_hready;
    // Gating with HRESETn drops a write whose final cycle collides with reset.
    assign w_we      = HRESETn && w_last && r_write;
    assign w_raddr   = r_hready ? w_haddr_w : r_addr;
    assign w_fwd_use = r_fwd_sel && r_fwd_vld && (r_fwd_addr == r_addr);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state   <= ST_IDLE;
            r_hready  <= 1'b1;
            r_hresp   <= HRESP_OKAY;
            r_cnt     <= 3'd0;
            r_write   <= 1'b0;
            r_fwd_sel <= 1'b0;
            r_fwd_vld <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr    <= w_haddr_w;
                r_mask    <= w_mask_in;
                r_write   <= HWRITE;
                r_fwd_sel <= w_we;
            end
            if (w_we) begin
                r_fwd_vld  <= 1'b1;
                r_fwd_addr <= r_addr;
                r_fwd_mask <= r_mask;
                r_fwd_data <= HWDATA;
            end
            if (r_hready) begin
                if (w_accept && w_legal) begin
                    r_state  <= ST_DATA;
                    r_cnt    <= 3'(WAIT_STATES);
                    r_hready <= (WAIT_STATES == 0);
                    r_hresp  <= HRESP_OKAY;
                end else if (w_accept) begin
                    r_state  <= ST_ERR1;
                    r_hready <= 1'b0;
                    r_hresp  <= HRESP_ERROR;
                end else begin
                    r_state  <= ST_IDLE;
                    r_hready <= 1'b1;
                    r_hresp  <= HRESP_OKAY;
                end
            end else if (r_state == ST_ERR1) begin
                r_state  <= ST_ERR2;
                r_hready <= 1'b1;
                r_hresp  <= HRESP_ERROR;
            end else begin
                r_cnt    <= r_cnt - 3'd1;
                r_hready <= (r_cnt == 3'd1);
            end
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        mfp_dual_port_ram #(
            .DATA_WIDTH (8),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_ram (
            .i_clk          (HCLK),
            .i_read_addr    (w_raddr),
            .i_write_addr   (r_addr),
            .i_write_data   (HWDATA[8*i +: 8]),
            .i_write_enable (w_we && r_mask[i]),
            .o_read_data    (w_ram_rdata[8*i +: 8])
        );
        assign w_merged[8*i +: 8] = (w_fwd_use && r_fwd_mask[i]) ? r_fwd_data[8*i +: 8]
                                                                 : w_ram_rdata[8*i +: 8];
    end

    assign HRDATA = (w_last && !r_write) ? w_merged : 32'd0;
    assign HREADY = r_hready;
    assign HRESP  = r_hresp;

endmodule
